// File: rtl/dmem_pkg.sv
// Shared types and constants for the RV32I data-memory responder.
// Optional build macro DMEM_MISALIGN_ERR_EN is consumed by dmem_responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response valid-ready bundle between the core load/store unit and the data memory.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store merge into the old word, load extraction/extension,
// and misalign/illegal-funct3 detection. Misaligned lanes are always forced down here.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  input  logic [31:0] rd_word,
  output logic [31:0] wr_word,
  output logic [31:0] ld_value,
  output logic        misalign,
  output logic        illegal
);

  logic [1:0]  eff_lane;
  logic [3:0]  be;
  logic [31:0] wshift;
  logic [31:0] rshift;

  always_comb begin
    misalign = 1'b0;
    illegal  = 1'b0;
    eff_lane = lane;
    case (funct3)
      F3_B, F3_BU: eff_lane = lane;
      F3_H, F3_HU: begin
        misalign = lane[0];
        eff_lane = {lane[1], 1'b0};
      end
      F3_W: begin
        misalign = |lane;
        eff_lane = 2'b00;
      end
      default: illegal = 1'b1;
    endcase
    // unsigned size codes only make sense for loads
    if (we && (funct3 == F3_BU || funct3 == F3_HU))
      illegal = 1'b1;
  end

  always_comb begin
    be = 4'b0000;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << eff_lane;
      2'b01:   be = 4'b0011 << eff_lane;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wshift = wdata << {eff_lane, 3'b000};
  assign rshift = rd_word >> {eff_lane, 3'b000};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_word[8*gi +: 8] = be[gi] ? wshift[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    ld_value = 32'h0;
    case (funct3)
      F3_B:    ld_value = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    ld_value = {{16{rshift[15]}}, rshift[15:0]};
      F3_W:    ld_value = rd_word;
      F3_BU:   ld_value = {24'h0, rshift[7:0]};
      F3_HU:   ld_value = {16'h0, rshift[15:0]};
      default: ld_value = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one request, waits WAIT_STATES cycles, accesses the array,
// then holds the response until taken. Define DMEM_MISALIGN_ERR_EN to flag misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
)
(
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit MISALIGN_ERR = 1'b1;
`else
  localparam bit MISALIGN_ERR = 1'b0;
`endif

  dmem_state_t state_reg, state_next;
  logic [3:0]  wait_cnt_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};

  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] word_idx;
  logic [31:0] old_word;
  logic [31:0] wr_word;
  logic [31:0] ld_value;
  logic        misalign;
  logic        illegal;
  logic        access_err;

  assign offset   = addr_reg - ADDR_BASE;
  assign in_range = {2'b00, offset[31:2]} < 32'(DEPTH_WORDS);
  assign word_idx = offset[AW+1:2];
  assign old_word = mem[word_idx];

  dmem_lane_align u_align (
    .we       (we_reg),
    .funct3   (funct3_reg),
    .lane     (offset[1:0]),
    .wdata    (wdata_reg),
    .old_word (old_word),
    .rd_word  (old_word),
    .wr_word  (wr_word),
    .ld_value (ld_value),
    .misalign (misalign),
    .illegal  (illegal)
  );

  assign access_err = !in_range || illegal || (MISALIGN_ERR && misalign);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req_valid) state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (wait_cnt_reg == 4'd0) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_reg == IDLE) && !reset;
    bus.rsp_valid = (state_reg == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_reg <= 4'd0;
      we_reg       <= 1'b0;
      funct3_reg   <= 3'b000;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
    end else if (state_reg == IDLE && bus.req_valid) begin
      wait_cnt_reg <= WAIT_LOAD;
      we_reg       <= bus.req_we;
      funct3_reg   <= bus.req_funct3;
      addr_reg     <= bus.req_addr;
      wdata_reg    <= bus.req_wdata;
    end else if (state_reg == WAIT && wait_cnt_reg != 4'd0) begin
      wait_cnt_reg <= wait_cnt_reg - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else if (state_reg == ACCESS) begin
      err_reg   <= access_err;
      rdata_reg <= (access_err || we_reg) ? 32'h0 : ld_value;
    end
  end

  // an asynchronous reset forces IDLE before the edge, so an aborted access never writes
  always_ff @(posedge clk) begin
    if (state_reg == ACCESS && we_reg && !access_err)
      mem[word_idx] <= wr_word;
  end

  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model plus directed loads/stores with literal expectations.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WS    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .ADDR_BASE   (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] mdl [DEPTH*4];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Reference: memory as a flat byte array, sizes and extension from funct3 rules.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int unsigned word, lane, nb;
    logic [31:0] v;
    bit          bad;
    e    = '0;
    word = int'(addr / 4);
    lane = int'(addr % 4);
    case (f3)
      3'b000, 3'b100: nb = 1;
      3'b001, 3'b101: nb = 2;
      3'b010:         nb = 4;
      default:        nb = 0;
    endcase
    bad = (nb == 0) || (we && f3[2]) || (word >= DEPTH);
    if (nb != 0 && (lane % nb) != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
      bad = 1'b1;
`else
      lane = lane - (lane % nb);
`endif
    end
    if (bad) begin
      e.err = 1'b1;
      return e;
    end
    if (we) begin
      for (int i = 0; i < int'(nb); i++) mdl[word*4 + lane + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(nb); i++) v = v | (32'(mdl[word*4 + lane + i]) << (8*i));
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      e.rdata = v;
    end
    return e;
  endfunction

  // Every cycle a response is presented it must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1, want 0");
      end else begin
        check("cmp_rdata", bus.rsp_rdata, exp_q[0].rdata);
        check("cmp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
        check("cmp_req_ready_in_resp", 32'(bus.req_ready), 32'h0);
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        input logic [31:0] lit_rdata, input logic lit_err);
    exp_t        e;
    int          n;
    logic [31:0] held;
    @(negedge clk);
    check({name, "/req_ready_idle"}, 32'(bus.req_ready), 32'h1);
    e = model(we, f3, addr, wd);
    exp_q.push_back(e);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "/latency"}, 32'(n), 32'(WS + 1));
    check({name, "/rdata"}, bus.rsp_rdata, lit_rdata);
    check({name, "/err"}, 32'(bus.rsp_err), 32'(lit_err));
    for (int i = 0; i < hold; i++) begin
      held = bus.rsp_rdata;
      @(posedge clk);
      #1;
      check({name, "/hold_valid"}, 32'(bus.rsp_valid), 32'h1);
      check({name, "/hold_rdata"}, bus.rsp_rdata, held);
      check({name, "/hold_req_ready"}, 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({name, "/valid_after_hs"}, 32'(bus.rsp_valid), 32'h0);
    check({name, "/ready_after_hs"}, 32'(bus.req_ready), 32'h1);
    $display("txn %-10s we=%0d f3=%03b addr=%08h wdata=%08h -> rdata=%08h err=%0d",
             name, we, f3, addr, wd, lit_rdata, lit_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h00;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    reset          = 1'b1;
    #1;
    check("rst/req_ready", 32'(bus.req_ready), 32'h0);
    check("rst/rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst/rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst/rsp_err", 32'(bus.rsp_err), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst/req_ready_after", 32'(bus.req_ready), 32'h1);

    do_req("sw10",   1'b1, F3_W,  32'h10, 32'hDEAD_BEEF, 0, 32'h0,         1'b0);
    do_req("lw10",   1'b0, F3_W,  32'h10, 32'h0,         0, 32'hDEAD_BEEF, 1'b0);
    do_req("sw20",   1'b1, F3_W,  32'h20, 32'h1122_3344, 0, 32'h0,         1'b0);
    do_req("sb21",   1'b1, F3_B,  32'h21, 32'h0000_00AA, 0, 32'h0,         1'b0);
    do_req("lw20",   1'b0, F3_W,  32'h20, 32'h0,         0, 32'h1122_AA44, 1'b0);
    do_req("lb21",   1'b0, F3_B,  32'h21, 32'h0,         0, 32'hFFFF_FFAA, 1'b0);
    do_req("lbu21",  1'b0, F3_BU, 32'h21, 32'h0,         0, 32'h0000_00AA, 1'b0);
    do_req("sh32",   1'b1, F3_H,  32'h32, 32'h0000_8001, 0, 32'h0,         1'b0);
    do_req("lh32",   1'b0, F3_H,  32'h32, 32'h0,         0, 32'hFFFF_8001, 1'b0);
    do_req("lhu32",  1'b0, F3_HU, 32'h32, 32'h0,         0, 32'h0000_8001, 1'b0);
    do_req("lb33",   1'b0, F3_B,  32'h33, 32'h0,         0, 32'hFFFF_FF80, 1'b0);
    do_req("sw_oor", 1'b1, F3_W,  32'(DEPTH*4), 32'h1234_5678, 0, 32'h0,   1'b1);
    do_req("lw_oor", 1'b0, F3_W,  32'(DEPTH*4), 32'h0,    0, 32'h0,         1'b1);
    do_req("lw0",    1'b0, F3_W,  32'h0,  32'h0,         0, 32'h0,         1'b0);
    do_req("f3_011", 1'b0, 3'b011, 32'h10, 32'h0,        0, 32'h0,         1'b1);
    do_req("sbu14",  1'b1, F3_BU, 32'h14, 32'h0000_00FF, 0, 32'h0,         1'b1);
    do_req("lw14",   1'b0, F3_W,  32'h14, 32'h0,         0, 32'h0,         1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
    do_req("lw12",   1'b0, F3_W,  32'h12, 32'h0,         0, 32'h0,         1'b1);
    do_req("lh33",   1'b0, F3_H,  32'h33, 32'h0,         0, 32'h0,         1'b1);
`else
    do_req("lw12",   1'b0, F3_W,  32'h12, 32'h0,         0, 32'hDEAD_BEEF, 1'b0);
    do_req("lh33",   1'b0, F3_H,  32'h33, 32'h0,         0, 32'hFFFF_8001, 1'b0);
`endif
    do_req("lw_hold", 1'b0, F3_W, 32'h10, 32'h0,         5, 32'hDEAD_BEEF, 1'b0);

    // Abort a store in WAIT with reset; the model is deliberately not updated.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h5555_5555;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort/req_ready_in_reset", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort/req_ready_idle", 32'(bus.req_ready), 32'h1);
    repeat (5) @(posedge clk);
    #1;
    check("abort/no_rsp", 32'(bus.rsp_valid), 32'h0);
    $display("txn abort_sw  we=1 f3=010 addr=00000010 wdata=55555555 -> aborted by reset");
    do_req("lw_after", 1'b0, F3_W, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
